spi_mem_bridge: RTL
===================

Name: spi_mem_bridge

Overview:
- Sits between the rv32i pipeline core and one external SPI memory (code plus data, one 24-bit byte address space).
- Serially fetches the instruction at pc_f, then performs the data-side access for the M stage.
- Holds the core frozen via stall while either transaction runs, then releases it for exactly one clk cycle per pipeline step.

Parameters:
- CLK_DIV, 1: SCK half-period in clk cycles (≥1).
- CS_GAP, 2: minimum clk cycles spi_cs_n stays high between transactions (≥1).
- ADDR_BITS, 24: SPI address field width; the low ADDR_BITS of the byte address are sent.

Ports:
- clk input 1: system clock.
- reset_n input 1: asynchronous, active-low reset.
- pc_f input 32: fetch address from core.
- alu_result_m input 32: data byte address from core M stage.
- write_data_m input 32: store data from core.
- mem_write_m input 1: store request from core.
- inst_f output 32: fetched instruction, registered.
- read_data_m output 32: loaded data word, registered.
- stall output 1: freezes the core when high.
- spi_sck output 1: SPI clock, mode 0.
- spi_cs_n output 1: chip select, active-low.
- spi_mosi output 1: serial data out.
- spi_miso input 1: serial data in.

Behaviour:
- Reset values (async on reset_n low, any state): inst_f = 32'h00000013 (NOP), read_data_m = 0, stall = 1, spi_sck = 0, spi_cs_n = 1, spi_mosi = 0, state = FETCH_START. Reset mid-transaction aborts it: cs_n goes high immediately and no partial data updates any output.
- FSM states: FETCH_START → FETCH_XFER → GAP1 → DATA_START → DATA_XFER → GAP2 → ADVANCE → FETCH_START.
- stall is 0 only in ADVANCE, which lasts exactly 1 clk. It is 1 in every other state.
- *_START (1 clk):
  - Latch the address (pc_f, or alu_result_m), the operation, and write_data_m into a 64-bit shift register.
  - Drive cs_n low.
  - Present the first bit on mosi.
- Frame: 8-bit command, then ADDR_BITS address bits, then 32 data bits, 64 bits total at default.
  - Command is 8'h03 (READ) for fetch and for data with mem_write_m = 0.
  - Command is 8'h02 (WRITE) when mem_write_m = 1.
  - Command and address are sent MSB first.
- Data byte order is little-endian:
  - Byte at addr+0 is transferred first, then +1, +2, +3.
  - Each byte is sent MSB first.
  - Assembled word = {b3, b2, b1, b0}. Write data is sent as write_data_m[7:0] first.
- SCK timing, mode 0:
  - sck idles low and toggles every CLK_DIV clks while cs_n is low.
  - mosi changes on the clk where sck falls (first bit is set in START).
  - miso is sampled on the clk where sck rises.
  - Each transfer is 64 sck periods = 128·CLK_DIV clks. sck ends low, then cs_n rises.
- Transfer completion:
  - A fetch loads inst_f from the 32 sampled data bits on the clk cs_n rises.
  - A data read loads read_data_m the same way.
  - A data write leaves read_data_m unchanged. miso is ignored during writes.
- GAP1/GAP2: cs_n high, sck low, for CS_GAP clks.
- Step period at defaults: 1 + 127 + 2 + 1 + 127 + 2 + 1 = 261 clks. Fetch happens first so that the core's delayed M-stage stall has settled before the data inputs are latched in DATA_START.
- Inputs are sampled only in *_START states. Changes elsewhere are ignored.
- The address ignores bits above ADDR_BITS, which wrap modulo 2^ADDR_BITS. Misaligned addresses are sent unmodified; the memory handles the byte sequence.
- The data transaction always occurs, as a read when mem_write_m = 0, because the core exports no read-enable.

Test Plan:
- Reset then release, memory model with word 32'h00500093 at byte 0:
  - cs_n falls at the first clk.
  - mosi frame is 03 000000.
  - inst_f = 32'h00500093 after fetch.
  - stall low for exactly 1 clk at cycle 261.
- pc_f = 32'h00000104, mem bytes [104..107] = 13 05 a0 00 → inst_f = 32'h00a00513. Check byte-order assembly.
- mem_write_m = 1, alu_result_m = 100, write_data_m = 25 → data frame is 02 000064 19 00 00 00. read_data_m unchanged.
- mem_write_m = 0, alu_result_m = 32'h01000010, mem[000010..13] = ef be ad de:
  - Address wraps to 24'h000010.
  - read_data_m = 32'hdeadbeef.
- Assert reset_n low midway through DATA_XFER:
  - cs_n high and sck low within the same cycle (async).
  - stall = 1, inst_f = 32'h13.
  - After release, the next frame starts with FETCH.
- CLK_DIV = 3, CS_GAP = 4:
  - sck period = 6 clks.
  - cs_n high gap = 4 clks.
  - Step period = 2 + 2·(128·3 − 1) + 2·4 + 1 = 777 clks.

Source files
------------

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge
//   Bridges a single-cycle-per-step rv32i pipeline to one serial SPI memory
//   that holds both code and data in a single byte address space. Each
//   pipeline step runs an instruction fetch at pc_f, then one data access for
//   the M stage (a read unless mem_write_m is set), and then releases the core
//   for exactly one clk.
//
//   Frame on the wire (mode 0, MSB first per field):
//     8-bit command (03 read / 02 write), ADDR_BITS address bits, then four
//     data bytes in little-endian order (byte at addr+0 first, each byte MSB
//     first).
//
// Parameters
//   CLK_DIV   : SCK half-period in clk cycles (>= 1)
//   CS_GAP    : minimum clk cycles spi_cs_n stays high between frames (>= 1)
//   ADDR_BITS : address field width, 1..32; upper address bits are dropped
//
// Ports
//   clk, reset_n              : system clock, asynchronous active-low reset
//   pc_f                      : fetch byte address
//   alu_result_m              : data byte address
//   write_data_m, mem_write_m : store data and store request
//   inst_f                    : fetched instruction (registered)
//   read_data_m               : loaded data word (registered)
//   stall                     : high freezes the core
//   spi_sck, spi_cs_n,
//   spi_mosi, spi_miso        : SPI master pins
module spi_mem_bridge #(
  parameter int CLK_DIV   = 1,
  parameter int CS_GAP    = 2,
  parameter int ADDR_BITS = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_f,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic        mem_write_m,
  output logic [31:0] inst_f,
  output logic [31:0] read_data_m,
  output logic        stall,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int FRAME_W   = 8 + ADDR_BITS + 32;
  localparam int EDGES     = 2 * FRAME_W;
  // START plus XFER together span the whole chip-select-low window; the last
  // SCK fall lands in the first gap cycle.
  localparam int XFER_CLKS = EDGES * CLK_DIV - 1;
  localparam int CNT_W     = $clog2(XFER_CLKS + CS_GAP + 1);
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W    = $clog2(EDGES);

  localparam logic [CNT_W-1:0]  XFER_LAST = CNT_W'(XFER_CLKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CS_GAP - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

  typedef enum logic [2:0] {
    FETCH_START,
    FETCH_XFER,
    GAP1,
    DATA_START,
    DATA_XFER,
    GAP2,
    ADVANCE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr;

  logic [DIV_W-1:0]   div_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic               op_fetch;
  logic               op_write;
  logic [FRAME_W-2:0] tx_rest;
  logic [31:0]        rx_sh;

  logic               start;
  logic               start_fetch;
  logic [31:0]        addr_sel;
  logic               wr_sel;
  logic [FRAME_W-1:0] frame;
  logic               tick;
  logic               rise;
  logic               fall;
  logic               last;
  logic               unused_addr;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic                 wr,
    input logic [ADDR_BITS-1:0] addr,
    input logic [31:0]          wdata
  );
    return {(wr ? 8'h02 : 8'h03), addr, byte_swap(wdata)};
  endfunction

  // Sequencer: one fetch frame, one data frame, one released clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH_START;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr) cnt <= '0;
      else         cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    stall     = 1'b1;
    case (state)
      FETCH_START: begin
        state_nxt = FETCH_XFER;
        cnt_clr   = 1'b1;
      end
      FETCH_XFER: begin
        if (cnt == XFER_LAST) begin
          state_nxt = GAP1;
          cnt_clr   = 1'b1;
        end
      end
      GAP1: begin
        if (cnt == GAP_LAST) begin
          state_nxt = DATA_START;
          cnt_clr   = 1'b1;
        end
      end
      DATA_START: begin
        state_nxt = DATA_XFER;
        cnt_clr   = 1'b1;
      end
      DATA_XFER: begin
        if (cnt == XFER_LAST) begin
          state_nxt = GAP2;
          cnt_clr   = 1'b1;
        end
      end
      GAP2: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ADVANCE;
          cnt_clr   = 1'b1;
        end
      end
      ADVANCE: begin
        stall     = 1'b0;
        state_nxt = FETCH_START;
        cnt_clr   = 1'b1;
      end
      default: begin
        state_nxt = FETCH_START;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Frame assembly from the core inputs, only consumed in the START states.
  assign start       = (state == FETCH_START) || (state == DATA_START);
  assign start_fetch = (state == FETCH_START);
  assign addr_sel    = start_fetch ? pc_f : alu_result_m;
  assign wr_sel      = !start_fetch && mem_write_m;
  assign frame       = build_frame(wr_sel, addr_sel[ADDR_BITS-1:0], write_data_m);
  // Address bits above ADDR_BITS are intentionally dropped.
  assign unused_addr = ^addr_sel;

  // SCK engine: runs off the chip-select register, independent of the
  // sequencer, so the final falling edge can close the frame by itself.
  assign tick = !spi_cs_n && (div_cnt == DIV_LAST);
  assign rise = tick && !spi_sck;
  assign fall = tick && spi_sck;
  assign last = fall && (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_cs_n    <= 1'b1;
      spi_sck     <= 1'b0;
      spi_mosi    <= 1'b0;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      op_fetch    <= 1'b0;
      op_write    <= 1'b0;
      inst_f      <= 32'h0000_0013;
      read_data_m <= 32'h0000_0000;
    end else if (start) begin
      spi_cs_n <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= frame[FRAME_W-1];
      div_cnt  <= '0;
      edge_cnt <= '0;
      op_fetch <= start_fetch;
      op_write <= wr_sel;
    end else if (!spi_cs_n) begin
      if (tick) begin
        div_cnt  <= '0;
        spi_sck  <= ~spi_sck;
        edge_cnt <= edge_cnt + EDGE_W'(1);
        if (last) begin
          // rx_sh already holds all 32 data bits, first-received byte on top.
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
          if (op_fetch)      inst_f      <= byte_swap(rx_sh);
          else if (!op_write) read_data_m <= byte_swap(rx_sh);
        end else if (fall) begin
          spi_mosi <= tx_rest[FRAME_W-2];
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Shift registers carry only data; their contents are meaningless until a
  // frame has been loaded, so they need no reset.
  always_ff @(posedge clk) begin
    if (start)     tx_rest <= frame[FRAME_W-2:0];
    else if (fall) tx_rest <= {tx_rest[FRAME_W-3:0], 1'b0};
    if (rise)      rx_sh   <= {rx_sh[30:0], spi_miso};
  end

endmodule
